// File: rtl/qar_pkg.sv
// Shared definitions for the writeback port arbiter and its pending-write scoreboard.
package qar_pkg;

   // Default register address width (2**QAR_AW registers, x0 hardwired to zero)
   localparam int QAR_AW = 5;

   // Default register data width
   localparam int QAR_DW = 32;

   // Requester encodings, also used as the round-robin pointer value
   typedef enum logic {
      REQ_ALU = 1'b0,
      REQ_LSU = 1'b1
   } req_e;

   // The requester that should be favoured after the given one has been served
   function automatic req_e otherReq(input req_e served);
      return (served == REQ_ALU) ? REQ_LSU : REQ_ALU;
   endfunction

endpackage

// File: rtl/wb_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, set when a
// destination is issued and cleared when the regfile write for it lands.
// Also detects the two protocol errors (double issue, unowned writeback).
module wb_scoreboard
   import qar_pkg::*;
#(
   parameter int AW = QAR_AW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_issValid,
   input  logic [AW-1:0] i_issRd,
   input  logic          i_wbGrant,
   input  logic [AW-1:0] i_wbRd,
   input  logic          i_clrValid,
   input  logic [AW-1:0] i_clrRd,
   input  logic [AW-1:0] i_qRs1,
   input  logic [AW-1:0] i_qRs2,
   output logic          o_qBusy1,
   output logic          o_qBusy2,
   output logic          o_err
);

   localparam int NREG = 1 << AW;

   logic [NREG-1:0] r_pending;
   logic [NREG-1:0] w_setMask;
   logic [NREG-1:0] w_clrMask;
   logic [NREG-1:0] w_pendingNext;
   logic            r_err;
   logic            w_issConflict;
   logic            w_wbUnowned;

   // Build set/clear masks; a set on the same edge as a clear wins, x0 never pends
   always_comb begin
      w_setMask = '0;
      w_clrMask = '0;
      if (i_issValid && (i_issRd != '0)) begin
         w_setMask[i_issRd] = 1'b1;
      end
      if (i_clrValid && (i_clrRd != '0)) begin
         w_clrMask[i_clrRd] = 1'b1;
      end
      w_pendingNext    = (r_pending & ~w_clrMask) | w_setMask;
      w_pendingNext[0] = 1'b0;
   end

   // Issuing a register that is still pending and not retiring on this edge
   assign w_issConflict = i_issValid && (i_issRd != '0) &&
                          r_pending[i_issRd] && !w_clrMask[i_issRd];

   // Accepting a writeback for a register nobody issued
   assign w_wbUnowned = i_wbGrant && (i_wbRd != '0) && !r_pending[i_wbRd];

   // Pending bits and sticky error flag
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pending <= '0;
         r_err     <= 1'b0;
      end else begin
         r_pending <= w_pendingNext;
         if (w_issConflict || w_wbUnowned) begin
            r_err <= 1'b1;
         end
      end
   end

   // Hazard queries look only at registered state, never the same-cycle issue or clear
   assign o_qBusy1 = (i_qRs1 != '0) && r_pending[i_qRs1];
   assign o_qBusy2 = (i_qRs2 != '0) && r_pending[i_qRs2];
   assign o_err    = r_err;

   // x0 can never be marked pending
   x0NeverPending : assert property (@(posedge clk) disable iff (rst) !r_pending[0]);

endmodule

// File: rtl/wb_port_arbiter.sv
// Writeback port arbiter: shares the single regfile write port between the
// ALU and the load/store unit, registers the winning write, and keeps the
// pending-write scoreboard that the issue stage queries for RAW hazards.
module wb_port_arbiter
   import qar_pkg::*;
#(
   parameter int AW    = QAR_AW,
   parameter int DW    = QAR_DW,
   parameter bit RR_EN = 1'b1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          alu_valid,
   output logic          alu_ready,
   input  logic [AW-1:0] alu_rd,
   input  logic [DW-1:0] alu_data,
   input  logic          lsu_valid,
   output logic          lsu_ready,
   input  logic [AW-1:0] lsu_rd,
   input  logic [DW-1:0] lsu_data,
   input  logic          iss_valid,
   input  logic [AW-1:0] iss_rd,
   input  logic [AW-1:0] q_rs1,
   input  logic [AW-1:0] q_rs2,
   output logic          q_busy1,
   output logic          q_busy2,
   output logic          rf_we,
   output logic [AW-1:0] rf_waddr,
   output logic [DW-1:0] rf_wdata,
   output logic          err
);

   req_e          r_rrPtr;
   logic          w_grantAlu;
   logic          w_grantLsu;
   logic          w_grant;
   req_e          w_grantSide;
   logic [AW-1:0] w_grantRd;
   logic [DW-1:0] w_grantData;
   logic          r_rfWe;
   logic [AW-1:0] r_rfWaddr;
   logic [DW-1:0] r_rfWdata;

   // Pick at most one winner; contention goes to the ALU in fixed mode or to the favoured side
   always_comb begin
      w_grantAlu = 1'b0;
      w_grantLsu = 1'b0;
      if (alu_valid && lsu_valid) begin
         if (!RR_EN || (r_rrPtr == REQ_ALU)) begin
            w_grantAlu = 1'b1;
         end else begin
            w_grantLsu = 1'b1;
         end
      end else begin
         w_grantAlu = alu_valid;
         w_grantLsu = lsu_valid;
      end
   end

   assign w_grant     = w_grantAlu | w_grantLsu;
   assign w_grantSide = w_grantLsu ? REQ_LSU : REQ_ALU;
   assign w_grantRd   = (w_grantSide == REQ_LSU) ? lsu_rd   : alu_rd;
   assign w_grantData = (w_grantSide == REQ_LSU) ? lsu_data : alu_data;

   assign alu_ready = w_grantAlu;
   assign lsu_ready = w_grantLsu;

   // Favour the side that was not served last; only an actual grant moves the pointer
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rrPtr <= REQ_ALU;
      end else if (w_grant) begin
         r_rrPtr <= otherReq(w_grantSide);
      end
   end

   // Register the granted write; x0 is consumed without raising the write enable
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rfWe    <= 1'b0;
         r_rfWaddr <= '0;
         r_rfWdata <= '0;
      end else begin
         r_rfWe <= w_grant && (w_grantRd != '0);
         if (w_grant) begin
            r_rfWaddr <= w_grantRd;
            r_rfWdata <= w_grantData;
         end
      end
   end

   assign rf_we    = r_rfWe;
   assign rf_waddr = r_rfWaddr;
   assign rf_wdata = r_rfWdata;

   wb_scoreboard #(
      .AW(AW)
   ) u_scoreboard (
      .clk        (clk),
      .rst        (rst),
      .i_issValid (iss_valid),
      .i_issRd    (iss_rd),
      .i_wbGrant  (w_grant),
      .i_wbRd     (w_grantRd),
      .i_clrValid (r_rfWe),
      .i_clrRd    (r_rfWaddr),
      .i_qRs1     (q_rs1),
      .i_qRs2     (q_rs2),
      .o_qBusy1   (q_busy1),
      .o_qBusy2   (q_busy2),
      .o_err      (err)
   );

   // Never hand the port to both requesters at once
   oneReady : assert property (@(posedge clk) disable iff (rst) !(alu_ready && lsu_ready));

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed scenarios with literal expectations plus
// randomized protocol-correct traffic checked every cycle against a model.
module tb_wb_port_arbiter;

   localparam int AW = 5;
   localparam int DW = 32;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst;
   logic          alu_valid, alu_ready, lsu_valid, lsu_ready;
   logic [AW-1:0] alu_rd, lsu_rd, iss_rd, q_rs1, q_rs2, rf_waddr;
   logic [DW-1:0] alu_data, lsu_data, rf_wdata;
   logic          iss_valid, q_busy1, q_busy2, rf_we, err;

   logic          fx_alu_valid, fx_alu_ready, fx_lsu_valid, fx_lsu_ready;
   logic [AW-1:0] fx_alu_rd, fx_lsu_rd, fx_iss_rd, fx_rf_waddr;
   logic [DW-1:0] fx_alu_data, fx_lsu_data, fx_rf_wdata;
   logic          fx_iss_valid, fx_q_busy1, fx_q_busy2, fx_rf_we, fx_err;

   int checkCount = 0;
   int errCount   = 0;

   // Round-robin instance: target of the model and all directed tests but one
   wb_port_arbiter #(.AW(AW), .DW(DW), .RR_EN(1'b1)) dut (
      .clk(clk), .rst(rst),
      .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
      .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
      .iss_valid(iss_valid), .iss_rd(iss_rd), .q_rs1(q_rs1), .q_rs2(q_rs2),
      .q_busy1(q_busy1), .q_busy2(q_busy2),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .err(err)
   );

   // Fixed-priority instance for the ALU-always-wins scenario
   wb_port_arbiter #(.AW(AW), .DW(DW), .RR_EN(1'b0)) dutFx (
      .clk(clk), .rst(rst),
      .alu_valid(fx_alu_valid), .alu_ready(fx_alu_ready), .alu_rd(fx_alu_rd), .alu_data(fx_alu_data),
      .lsu_valid(fx_lsu_valid), .lsu_ready(fx_lsu_ready), .lsu_rd(fx_lsu_rd), .lsu_data(fx_lsu_data),
      .iss_valid(fx_iss_valid), .iss_rd(fx_iss_rd), .q_rs1(5'd1), .q_rs2(5'd2),
      .q_busy1(fx_q_busy1), .q_busy2(fx_q_busy2),
      .rf_we(fx_rf_we), .rf_waddr(fx_rf_waddr), .rf_wdata(fx_rf_wdata), .err(fx_err)
   );

   // Regfile fed by the DUT write port; x0 ignores writes
   logic [DW-1:0] rfMem [32];
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) rfMem[i] <= '0;
      end else if (rf_we && (rf_waddr != '0)) begin
         rfMem[rf_waddr] <= rf_wdata;
      end
   end

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Behavioural model state: what the outputs must be during the current cycle
   bit            mPending [32];
   logic [DW-1:0] mRegs [32] = '{default: '0};
   bit            mWe = 1'b0;
   logic [AW-1:0] mWaddr = '0;
   logic [DW-1:0] mWdata = '0;
   bit            mErr = 1'b0;
   bit            mLastLsu = 1'b1;
   bit            mAluAcc = 1'b0;
   bit            mLsuAcc = 1'b0;
   bit            eAlu, eLsu, eGrant;
   logic [AW-1:0] gRd;
   logic [DW-1:0] gData;

   // Compare every cycle, then advance the model across the coming edge
   always @(negedge clk) begin
      if (alu_valid && lsu_valid) begin
         eAlu = mLastLsu;
         eLsu = !mLastLsu;
      end else begin
         eAlu = alu_valid;
         eLsu = lsu_valid;
      end
      checkOutput("alu_ready", alu_ready, eAlu);
      checkOutput("lsu_ready", lsu_ready, eLsu);
      checkOutput("q_busy1", q_busy1, (q_rs1 != 0) && mPending[q_rs1]);
      checkOutput("q_busy2", q_busy2, (q_rs2 != 0) && mPending[q_rs2]);
      checkOutput("rf_we", rf_we, mWe);
      checkOutput("rf_waddr", rf_waddr, mWaddr);
      checkOutput("rf_wdata", rf_wdata, mWdata);
      checkOutput("err", err, mErr);
      mAluAcc = eAlu;
      mLsuAcc = eLsu;
      if (rst) begin
         for (int i = 0; i < 32; i++) begin
            mPending[i] = 1'b0;
            mRegs[i] = '0;
         end
         mWe = 1'b0; mWaddr = '0; mWdata = '0; mErr = 1'b0; mLastLsu = 1'b1;
      end else begin
         eGrant = eAlu || eLsu;
         gRd    = eLsu ? lsu_rd : alu_rd;
         gData  = eLsu ? lsu_data : alu_data;
         if (iss_valid && iss_rd != 0 && mPending[iss_rd] && !(mWe && mWaddr == iss_rd)) mErr = 1'b1;
         if (eGrant && gRd != 0 && !mPending[gRd]) mErr = 1'b1;
         if (mWe) begin
            mRegs[mWaddr] = mWdata;
            mPending[mWaddr] = 1'b0;
         end
         if (iss_valid && iss_rd != 0) mPending[iss_rd] = 1'b1;
         mWe = eGrant && (gRd != 0);
         if (eGrant) begin
            mWaddr = gRd;
            mWdata = gData;
         end
         if (eAlu) mLastLsu = 1'b0;
         else if (eLsu) mLastLsu = 1'b1;
      end
   end

   int            wbQ [$];
   int            cand;
   int            r;
   int            aRd [4] = '{8, 10, 10, 0};
   int            lRd [4] = '{9, 9, 11, 11};
   bit            expA [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

   // Randomized protocol-correct traffic: holds requests until accepted, issues only free registers
   task automatic applyStimulus(input int cycles);
      for (int c = 0; c < cycles; c++) begin
         tick();
         if (rst) begin
            rst = 1'b0;
            wbQ.delete();
            alu_valid = 1'b0;
            lsu_valid = 1'b0;
         end else begin
            if (alu_valid && mAluAcc) alu_valid = 1'b0;
            if (lsu_valid && mLsuAcc) lsu_valid = 1'b0;
         end
         if (!alu_valid) begin
            r = int'($urandom_range(0, 99));
            if (r < 45 && wbQ.size() > 0) begin
               alu_valid = 1'b1; alu_rd = 5'(wbQ.pop_front()); alu_data = $urandom();
            end else if (r < 50) begin
               alu_valid = 1'b1; alu_rd = '0; alu_data = $urandom();
            end
         end
         if (!lsu_valid) begin
            r = int'($urandom_range(0, 99));
            if (r < 45 && wbQ.size() > 0) begin
               lsu_valid = 1'b1; lsu_rd = 5'(wbQ.pop_back()); lsu_data = $urandom();
            end else if (r < 50) begin
               lsu_valid = 1'b1; lsu_rd = '0; lsu_data = $urandom();
            end
         end
         iss_valid = 1'b0;
         r = int'($urandom_range(0, 99));
         if (r < 55) begin
            for (int t = 0; t < 4; t++) begin
               cand = int'($urandom_range(1, 31));
               if (!iss_valid && !mPending[cand]) begin
                  iss_valid = 1'b1; iss_rd = 5'(cand); wbQ.push_back(cand);
               end
            end
         end else if (r < 60) begin
            iss_valid = 1'b1; iss_rd = '0;
         end
         q_rs1 = 5'($urandom_range(0, 31));
         q_rs2 = 5'($urandom_range(0, 31));
         rst = ($urandom_range(0, 399) == 0);
      end
   endtask

   initial begin
      rst = 1'b1;
      alu_valid = 0; alu_rd = '0; alu_data = '0;
      lsu_valid = 0; lsu_rd = '0; lsu_data = '0;
      iss_valid = 0; iss_rd = '0; q_rs1 = 5'd5; q_rs2 = '0;
      fx_alu_valid = 0; fx_alu_rd = '0; fx_alu_data = '0;
      fx_lsu_valid = 0; fx_lsu_rd = '0; fx_lsu_data = '0;
      fx_iss_valid = 0; fx_iss_rd = '0;
      repeat (2) tick();
      #1;
      checkOutput("reset rf_we", rf_we, 0);
      checkOutput("reset rf_waddr", rf_waddr, 0);
      checkOutput("reset rf_wdata", rf_wdata, 0);
      checkOutput("reset err", err, 0);
      checkOutput("reset q_busy1", q_busy1, 0);
      checkOutput("reset fx err", fx_err, 0);
      rst = 1'b0;

      // 1: issue x5, ALU writes 123
      tick(); iss_valid = 1; iss_rd = 5'd5; #1;
      checkOutput("t1 busy same-cycle issue", q_busy1, 0);
      tick(); iss_valid = 0; alu_valid = 1; alu_rd = 5'd5; alu_data = 32'd123; #1;
      checkOutput("t1 alu_ready", alu_ready, 1);
      checkOutput("t1 busy pending", q_busy1, 1);
      checkOutput("t1 rf_we before", rf_we, 0);
      tick(); alu_valid = 0; #1;
      checkOutput("t1 rf_we", rf_we, 1);
      checkOutput("t1 rf_waddr", rf_waddr, 5);
      checkOutput("t1 rf_wdata", rf_wdata, 123);
      checkOutput("t1 busy until write", q_busy1, 1);
      tick(); #1;
      checkOutput("t1 rf_we after", rf_we, 0);
      checkOutput("t1 busy cleared", q_busy1, 0);
      checkOutput("t1 regfile x5", rfMem[5], 123);
      checkOutput("t1 waddr hold", rf_waddr, 5);

      // 2: round-robin alternation
      rst = 1; tick(); rst = 0;
      tick(); iss_valid = 1; iss_rd = 5'd3;
      tick(); iss_rd = 5'd4;
      tick(); iss_valid = 0;
      alu_valid = 1; alu_rd = 5'd3; alu_data = 32'd11;
      lsu_valid = 1; lsu_rd = 5'd4; lsu_data = 32'd22; #1;
      checkOutput("t2 alu first", alu_ready, 1);
      checkOutput("t2 lsu waits", lsu_ready, 0);
      tick(); alu_valid = 0; #1;
      checkOutput("t2 lsu next", lsu_ready, 1);
      checkOutput("t2 waddr alu", rf_waddr, 3);
      checkOutput("t2 wdata alu", rf_wdata, 11);
      tick(); lsu_valid = 0; #1;
      checkOutput("t2 waddr lsu", rf_waddr, 4);
      checkOutput("t2 wdata lsu", rf_wdata, 22);
      for (int k = 8; k < 12; k++) begin
         tick(); iss_valid = 1; iss_rd = 5'(k);
      end
      for (int k = 0; k < 4; k++) begin
         tick(); iss_valid = 0;
         alu_valid = 1; alu_rd = 5'(aRd[k]); alu_data = 32'(aRd[k] * 3);
         lsu_valid = 1; lsu_rd = 5'(lRd[k]); lsu_data = 32'(lRd[k] * 5); #1;
         checkOutput("t2 stream alu_ready", alu_ready, expA[k]);
         checkOutput("t2 stream lsu_ready", lsu_ready, !expA[k]);
      end
      tick(); lsu_valid = 0; #1;
      checkOutput("t2 alu x0 alone", alu_ready, 1);
      checkOutput("t2 last waddr", rf_waddr, 11);
      tick(); alu_valid = 0; #1;
      checkOutput("t2 x0 no we", rf_we, 0);
      checkOutput("t2 err", err, 0);

      // 3: fixed priority, ALU always wins
      for (int k = 1; k < 5; k++) begin
         tick(); fx_iss_valid = 1; fx_iss_rd = 5'(k);
      end
      for (int k = 0; k < 4; k++) begin
         tick(); fx_iss_valid = 0;
         fx_alu_valid = 1; fx_alu_rd = 5'(k + 1); fx_alu_data = 32'(k + 40);
         fx_lsu_valid = 1; fx_lsu_rd = 5'd9; fx_lsu_data = 32'd7; #1;
         checkOutput("t3 fx alu_ready", fx_alu_ready, 1);
         checkOutput("t3 fx lsu_ready", fx_lsu_ready, 0);
         if (k > 0) checkOutput("t3 fx waddr", fx_rf_waddr, 5'(k));
      end
      tick(); fx_alu_valid = 0; fx_lsu_valid = 0; #1;
      checkOutput("t3 fx final waddr", fx_rf_waddr, 4);
      checkOutput("t3 fx err", fx_err, 0);

      // 4: write to x0 is consumed silently
      tick(); alu_valid = 1; alu_rd = '0; alu_data = 32'd999; #1;
      checkOutput("t4 alu_ready", alu_ready, 1);
      tick(); alu_valid = 0; #1;
      checkOutput("t4 rf_we", rf_we, 0);
      checkOutput("t4 regfile x0", rfMem[0], 0);
      checkOutput("t4 err", err, 0);

      // 5: reissue on the clearing edge is legal, a second reissue is not
      q_rs1 = 5'd7;
      tick(); iss_valid = 1; iss_rd = 5'd7;
      tick(); iss_valid = 0; alu_valid = 1; alu_rd = 5'd7; alu_data = 32'd77;
      tick(); alu_valid = 0; iss_valid = 1; iss_rd = 5'd7; #1;
      checkOutput("t5 rf_we x7", rf_we, 1);
      checkOutput("t5 busy before", q_busy1, 1);
      tick(); iss_valid = 0; #1;
      checkOutput("t5 busy after set wins", q_busy1, 1);
      checkOutput("t5 err clean", err, 0);
      tick(); iss_valid = 1; iss_rd = 5'd7;
      tick(); iss_valid = 0; #1;
      checkOutput("t5 err set", err, 1);
      repeat (3) tick();
      #1;
      checkOutput("t5 err sticky", err, 1);

      // 6: reset while a write is in flight
      q_rs1 = 5'd6; q_rs2 = 5'd7;
      tick(); iss_valid = 1; iss_rd = 5'd6;
      tick(); iss_valid = 0; alu_valid = 1; alu_rd = 5'd6; alu_data = 32'd66; #1;
      checkOutput("t6 alu_ready", alu_ready, 1);
      tick(); alu_valid = 0; rst = 1; #1;
      checkOutput("t6 in flight", rf_we, 1);
      tick(); rst = 0; #1;
      checkOutput("t6 rf_we dropped", rf_we, 0);
      checkOutput("t6 busy1", q_busy1, 0);
      checkOutput("t6 busy2", q_busy2, 0);
      checkOutput("t6 err", err, 0);

      // Randomized traffic
      wbQ.delete();
      applyStimulus(3000);
      tick();
      rst = 0; alu_valid = 0; lsu_valid = 0; iss_valid = 0;
      repeat (2) tick();
      #1;
      for (int i = 0; i < 32; i++) begin
         checkOutput("regfile contents", rfMem[i], mRegs[i]);
      end

      $display("Result: errors=%0d of %0d checks", errCount, checkCount);
      $finish;
   end

   // Guard against a stalled run
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: run did not finish in time");
      $fatal(1, "[TB] timeout");
   end

endmodule
